pattern_job_sched: RTL

- Shares one serial pattern detector (1-bit `d`/`valid` in, registered match pulse out) between NREQ requesters.
- Each requester submits a WIDTH-bit word. The scheduler arbitrates round-robin, clears the detector, shifts the word in MSB-first and counts match pulses.
- It returns the match count to the winning requester with a one-hot done pulse.
- Sits between the per-channel front-ends and the single shared detector instance.

---
 rtl/pattern_pkg.sv | 18 +
 rtl/pattern_job_sched_rr_arbiter.sv | 43 ++++
 rtl/pattern_job_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern job scheduler: FSM encoding, detector symbols and defaults.
package pattern_pkg;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CLR   = 5'b00010,
    S_SHIFT = 5'b00100,
    S_DRAIN = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;

  localparam logic SYM_B = 1'b0;
  localparam logic SYM_C = 1'b1;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/pattern_job_sched_rr_arbiter.sv
// Round-robin selector: searches from last+1 upward (mod NREQ) and remembers the last winner.
module rr_arbiter import pattern_pkg::*; #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req,
  input  logic                    update,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] last
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] win;

  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    gnt   = '0;
    win   = last;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  // Pointer starts at NREQ-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last <= PW'(NREQ - 1);
    end else if (update && |req) begin
      last <= win;
    end
  end

endmodule

// File: rtl/pattern_job_sched.sv
// Shares one serial pattern detector between NREQ requesters: grant, clear, shift MSB-first,
// count match pulses, then return the count with a one-hot done pulse.
module pattern_job_sched import pattern_pkg::*; #(
  parameter  int NREQ      = DEF_NREQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int DRAIN_CYC = 1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic [CW-1:0]         count_o,
  output logic                  busy_o,
  output logic                  det_rst_o,
  output logic                  det_valid_o,
  output logic                  det_d_o,
  input  logic                  det_match_i
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(((WIDTH > DRAIN_CYC) ? WIDTH : DRAIN_CYC) + 1);

  state_e            state;
  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_last;
  logic [WIDTH-1:0]  sel_word;
  logic [WIDTH-1:0]  shreg;
  logic [TW-1:0]     cyc_cnt;
  logic [CW-1:0]     match_cnt;
  logic [CW-1:0]     cnt_next;
  logic              in_window;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req_i),
    .update (state == S_IDLE),
    .gnt    (arb_gnt),
    .last   (arb_last)
  );

  always_comb begin
    sel_word = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (arb_gnt[r]) sel_word = sel_word | data_i[r*WIDTH +: WIDTH];
    end
  end

  // The detector answers one cycle after each bit, so the first shift cycle can never
  // carry a real match and the drain cycles catch the answers to the last bits.
  always_comb begin
    in_window = ((state == S_SHIFT) && (cyc_cnt != '0)) || (state == S_DRAIN);
    cnt_next  = match_cnt;
    if (in_window && det_match_i && (match_cnt != CW'(WIDTH))) begin
      cnt_next = match_cnt + CW'(1);
    end
  end

  // The arbiter pointer holds the winner for the whole job, so done_o is decoded from it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      gnt_o       <= '0;
      done_o      <= '0;
      count_o     <= '0;
      busy_o      <= 1'b0;
      det_rst_o   <= 1'b1;
      det_valid_o <= 1'b0;
      det_d_o     <= 1'b0;
      shreg       <= '0;
      cyc_cnt     <= '0;
      match_cnt   <= '0;
    end else begin
      gnt_o     <= '0;
      done_o    <= '0;
      det_rst_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req_i) begin
            state     <= S_CLR;
            gnt_o     <= arb_gnt;
            shreg     <= sel_word;
            det_rst_o <= 1'b1;
            busy_o    <= 1'b1;
            match_cnt <= '0;
          end
        end
        S_CLR: begin
          state       <= S_SHIFT;
          det_valid_o <= 1'b1;
          det_d_o     <= shreg[WIDTH-1];
          shreg       <= shreg << 1;
          cyc_cnt     <= '0;
          match_cnt   <= '0;
        end
        S_SHIFT: begin
          match_cnt <= cnt_next;
          if (cyc_cnt == TW'(WIDTH - 1)) begin
            state       <= S_DRAIN;
            det_valid_o <= 1'b0;
            det_d_o     <= 1'b0;
            cyc_cnt     <= '0;
          end else begin
            det_d_o <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            cyc_cnt <= cyc_cnt + TW'(1);
          end
        end
        S_DRAIN: begin
          match_cnt <= cnt_next;
          if (cyc_cnt == TW'(DRAIN_CYC - 1)) begin
            state   <= S_DONE;
            done_o  <= NREQ'(1) << arb_last;
            count_o <= cnt_next;
          end else begin
            cyc_cnt <= cyc_cnt + TW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
